fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_STEP, default 32'd4: increment applied to the PC on each accepted fetch.
REQ-002 Parameter TIMEOUT, default 64: max consecutive un-acked request cycles before the block faults; legal range 1..255.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_pc  input  32  current PC from the PC register.
REQ-006 o_pc_next  output  32  next-PC value driven to the PC register.
REQ-007 o_pc_stall  output  1  holds the PC register when 1.
REQ-008 i_redirect  input  1  branch/jump taken; 1-cycle pulse.
REQ-009 i_redirect_pc  input  32  redirect target, valid with i_redirect.
REQ-010 o_imem_req  output  1  instruction memory request.
REQ-011 o_imem_addr  output  32  instruction memory address.
REQ-012 i_imem_ack  input  1  memory returns data; valid only while o_imem_req=1.
REQ-013 i_imem_rdata  input  32  instruction word, valid with i_imem_ack.
REQ-014 o_instr_valid  output  1  registered instruction held for decode.
REQ-015 o_instr  output  32  registered instruction word.
REQ-016 o_instr_pc  output  32  PC of o_instr.
REQ-017 i_id_ready  input  1  decode accepts o_instr this cycle.
REQ-018 o_fault  output  1  sticky fetch-timeout flag.

Function
REQ-019 FSM states IDLE, FETCH, HOLD, DISCARD, FAULT; IDLE -> FETCH unconditionally after one cycle.
REQ-020 o_imem_req = 1 in FETCH and DISCARD only; 0 in IDLE, HOLD, FAULT.
REQ-021 o_imem_addr = i_pc in FETCH; = latched discard address in DISCARD; = i_pc otherwise (don't-care).
REQ-022 Default: o_pc_stall=1, o_pc_next = i_pc + PC_STEP (32-bit, wraps modulo 2^32).
REQ-023 FETCH, i_imem_ack=1, i_redirect=0: o_pc_stall=0 that cycle; next edge o_instr<=i_imem_rdata, o_instr_pc<=i_pc, o_instr_valid<=1, state->HOLD.
REQ-024 HOLD, i_id_ready=1, i_redirect=0: o_instr_valid<=0, state->FETCH; i_id_ready=0: hold all instruction outputs stable.
REQ-025 i_redirect=1 in FETCH/HOLD/DISCARD: o_pc_stall=0, o_pc_next=i_redirect_pc that cycle; o_instr_valid<=0.
REQ-026 Redirect in FETCH with i_imem_ack=0: latch i_pc as discard address, state->DISCARD (request stays outstanding at the same address).
REQ-027 Redirect in FETCH with i_imem_ack=1: returned word dropped, state->FETCH (remains).
REQ-028 Redirect in HOLD: held instruction dropped, state->FETCH.
REQ-029 DISCARD: i_imem_ack=1 -> data dropped, state->FETCH; redirect in DISCARD updates PC only, stays DISCARD unless ack the same cycle.
REQ-030 Wait counter (8-bit): increments each FETCH/DISCARD cycle with o_imem_req=1 and i_imem_ack=0; clears on ack or on leaving FETCH/DISCARD; saturates at 255.
REQ-031 Counter reaching TIMEOUT-1 with no ack: next edge state->FAULT, o_fault<=1, o_instr_valid<=0.
REQ-032 FAULT: o_pc_stall=1, i_redirect and i_imem_ack ignored; exits only via i_reset.
REQ-033 At most one request outstanding; an ack never advances the PC twice.

Reset
REQ-034 i_reset=1 forces immediately: state IDLE, o_instr_valid=0, o_instr=0, o_instr_pc=0, o_fault=0, counter=0, discard address=0.
REQ-035 Reset asserted mid-request abandons the request; o_imem_req=0 while i_reset=1; first request issues 1 cycle after reset release.

Verification
REQ-036 Reset release, i_pc=0, ack after 2 wait cycles, rdata=32'h00000013 -> o_instr=32'h13, o_instr_pc=0, o_pc_next=4 with o_pc_stall=0 for exactly the ack cycle.
REQ-037 Valid held with i_id_ready=0 for 5 cycles -> o_instr, o_instr_pc stable, o_imem_req=0, o_pc_stall=1 throughout.
REQ-038 Redirect to 32'h100 during un-acked fetch of 32'h8 -> o_pc_next=32'h100 one cycle; o_imem_addr stays 32'h8 until ack; that data never appears as o_instr_valid; next request addr 32'h100.
REQ-039 Redirect coincident with ack, and redirect in HOLD -> no instruction delivered, next fetch at redirect target.
REQ-040 TIMEOUT=4, ack never given -> o_fault=1 after 4 request cycles, o_imem_req=0; later ack/redirect ignored; i_reset clears o_fault.
REQ-041 i_pc=32'hFFFFFFFC fetch acked -> o_pc_next=32'h00000000 (wrap).

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Bundles the PC-register, instruction-memory and decode handshakes of fetch_ctrl.
// The master modport is the fetch controller and the slave modport is its environment.
interface fetch_ctrl_if;
  logic [31:0] i_pc;
  logic [31:0] o_pc_next;
  logic        o_pc_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_id_ready;
  logic        o_fault;

  modport master (
    input  i_pc, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata, i_id_ready,
    output o_pc_next, o_pc_stall, o_imem_req, o_imem_addr,
           o_instr_valid, o_instr, o_instr_pc, o_fault
  );

  modport slave (
    output i_pc, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata, i_id_ready,
    input  o_pc_next, o_pc_stall, o_imem_req, o_imem_addr,
           o_instr_valid, o_instr, o_instr_pc, o_fault
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one request, holds the returned
// word for decode, squashes stale returns after a redirect and faults on a memory timeout.
module fetch_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  fetch_ctrl_if.master  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] HOLD    = 3'd2;
  localparam logic [2:0] DISCARD = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] discard_addr_q, discard_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;

  logic        pc_stall;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    discard_addr_d = discard_addr_q;
    instr_valid_d  = instr_valid_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    fault_d        = fault_q;
    pc_stall       = 1'b1;
    pc_next        = bus.i_pc + PC_STEP;
    imem_req       = 1'b0;
    imem_addr      = bus.i_pc;

    case (state_q)
      IDLE: begin
        wait_cnt_d = 8'd0;
        state_d    = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (bus.i_redirect) begin
          pc_stall      = 1'b0;
          pc_next       = bus.i_redirect_pc;
          instr_valid_d = 1'b0;
          if (bus.i_imem_ack) begin
            wait_cnt_d = 8'd0;
          end else begin
            // The request stays on the bus, so remember its address to retire it later.
            discard_addr_d = bus.i_pc;
            state_d        = DISCARD;
          end
        end else if (bus.i_imem_ack) begin
          pc_stall      = 1'b0;
          instr_d       = bus.i_imem_rdata;
          instr_pc_d    = bus.i_pc;
          instr_valid_d = 1'b1;
          wait_cnt_d    = 8'd0;
          state_d       = HOLD;
        end
      end

      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discard_addr_q;
        if (bus.i_redirect) begin
          pc_stall      = 1'b0;
          pc_next       = bus.i_redirect_pc;
          instr_valid_d = 1'b0;
        end
        if (bus.i_imem_ack) begin
          wait_cnt_d = 8'd0;
          state_d    = FETCH;
        end
      end

      HOLD: begin
        wait_cnt_d = 8'd0;
        if (bus.i_redirect) begin
          pc_stall      = 1'b0;
          pc_next       = bus.i_redirect_pc;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (bus.i_id_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end

      FAULT: begin
        wait_cnt_d = 8'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides any redirect-driven next state; the PC update still happens.
    if ((state_q == FETCH || state_q == DISCARD) && !bus.i_imem_ack) begin
      if (wait_cnt_q == LAST_WAIT) begin
        state_d       = FAULT;
        fault_d       = 1'b1;
        instr_valid_d = 1'b0;
        wait_cnt_d    = 8'd0;
      end else if (wait_cnt_q != 8'hFF) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    if (i_reset) begin
      state_q        <= IDLE;
      wait_cnt_q     <= 8'd0;
      discard_addr_q <= 32'd0;
      instr_valid_q  <= 1'b0;
      instr_q        <= 32'd0;
      instr_pc_q     <= 32'd0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      discard_addr_q <= discard_addr_d;
      instr_valid_q  <= instr_valid_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      fault_q        <= fault_d;
    end
  end

  assign bus.o_pc_next     = pc_next;
  assign bus.o_pc_stall    = pc_stall;
  assign bus.o_imem_req    = imem_req;
  assign bus.o_imem_addr   = imem_addr;
  assign bus.o_instr_valid = instr_valid_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_pc    = instr_pc_q;
  assign bus.o_fault       = fault_q;

endmodule
